// File: rtl/bp_me_wb_pkg.sv
// Shared Wishbone slave definitions: the slave state encoding and a helper
// that derives the byte-select width from the data width.
package bp_me_wb_pkg;

   typedef enum logic [1:0] {
      e_idle,
      e_wait,
      e_access,
      e_resp
   } state_e;

   function automatic int wb_sel_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM model with per-byte write enables.
// Contents are never reset; read data is registered on the access edge.
module bsg_mem_1rw_sync_mask_write_byte #(
   parameter  int width_p       = 64,
   parameter  int els_p         = 512,
   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int mask_width_lp = width_p / 8
) (
   input  logic                     clk_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   input  logic [mask_width_lp-1:0] write_mask_i,
   output logic [width_p-1:0]       data_o
);

   logic [width_p-1:0] mem_r [els_p];

   always_ff @(posedge clk_i) begin
      if (v_i & w_i) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (write_mask_i[b]) begin
               mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
      if (v_i & ~w_i) begin
         data_o <= mem_r[addr_i];
      end
   end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic slave in front of a byte-maskable synchronous SRAM,
// with optional wait states and an error response for out-of-range words.
module wb_sram_slave
   import bp_me_wb_pkg::*;
#(
   parameter  int data_width_p  = 64,
   parameter  int els_p         = 512,
   parameter  int wait_cycles_p = 0,
   localparam int addr_width_lp = ((els_p > 1) ? $clog2(els_p) : 1) + 1,
   localparam int sel_width_lp  = wb_sel_width(data_width_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [addr_width_lp-1:0] adr_i,
   input  logic [data_width_p-1:0]  dat_i,
   input  logic                     cyc_i,
   input  logic                     stb_i,
   input  logic [sel_width_lp-1:0]  sel_i,
   input  logic                     we_i,
   output logic [data_width_p-1:0]  dat_o,
   output logic                     ack_o,
   output logic                     err_o
);

   localparam int mem_addr_width_lp = addr_width_lp - 1;
   localparam int wait_width_lp     = $clog2(wait_cycles_p + 2);
   localparam logic [addr_width_lp-1:0] els_lp       = addr_width_lp'(els_p);
   localparam logic [wait_width_lp-1:0] wait_load_lp = wait_width_lp'(wait_cycles_p);
   localparam logic [wait_width_lp-1:0] wait_last_lp = wait_width_lp'(1);

   if (!(data_width_p == 8 || data_width_p == 16 || data_width_p == 32 || data_width_p == 64)) begin : g_bad_width
      $error("wb_sram_slave: data_width_p must be 8, 16, 32 or 64");
   end

   state_e                     state_r;
   logic [addr_width_lp-1:0]   adr_r;
   logic [data_width_p-1:0]    dat_r;
   logic [sel_width_lp-1:0]    sel_r;
   logic                       we_r;
   logic [wait_width_lp-1:0]   wait_cnt_r;
   logic                       ack_r;
   logic                       err_r;
   logic                       in_range;
   logic                       mem_v;
   logic [data_width_p-1:0]    mem_data;

   // The extra address MSB lets words at or beyond els_p be caught here.
   assign in_range = (adr_r < els_lp);
   assign mem_v    = (state_r == e_access) & in_range & ~reset_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= e_idle;
         adr_r      <= '0;
         dat_r      <= '0;
         sel_r      <= '0;
         we_r       <= 1'b0;
         wait_cnt_r <= '0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         ack_r <= 1'b0;
         err_r <= 1'b0;
         case (state_r)
            e_idle: begin
               if (cyc_i & stb_i) begin
                  adr_r <= adr_i;
                  dat_r <= dat_i;
                  sel_r <= sel_i;
                  we_r  <= we_i;
                  if (wait_cycles_p > 0) begin
                     wait_cnt_r <= wait_load_lp;
                     state_r    <= e_wait;
                  end else begin
                     state_r    <= e_access;
                  end
               end
            end
            // Dropping cyc during the wait abandons the request silently.
            e_wait: begin
               if (!cyc_i) begin
                  wait_cnt_r <= '0;
                  state_r    <= e_idle;
               end else if (wait_cnt_r == wait_last_lp) begin
                  wait_cnt_r <= '0;
                  state_r    <= e_access;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 1'b1;
               end
            end
            e_access: begin
               ack_r   <= in_range;
               err_r   <= ~in_range;
               state_r <= e_resp;
            end
            e_resp: begin
               state_r <= e_idle;
            end
            default: begin
               state_r <= e_idle;
            end
         endcase
      end
   end

   bsg_mem_1rw_sync_mask_write_byte #(
      .width_p (data_width_p),
      .els_p   (els_p)
   ) mem (
      .clk_i        (clk_i),
      .v_i          (mem_v),
      .w_i          (we_r),
      .addr_i       (adr_r[mem_addr_width_lp-1:0]),
      .data_i       (dat_r),
      .write_mask_i (sel_r),
      .data_o       (mem_data)
   );

   assign ack_o = ack_r;
   assign err_o = err_r;
   assign dat_o = ack_r ? mem_data : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: one instance with no wait states and
// one with three, driven by directed vectors with hand-computed responses.
module tb_wb_sram_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, cyc0, stb0, we0, ack0, err0;
   logic [9:0]  adr0;
   logic [63:0] dati0, dato0;
   logic [7:0]  sel0;
   logic        rst3, cyc3, stb3, we3, ack3, err3;
   logic [9:0]  adr3;
   logic [63:0] dati3, dato3;
   logic [7:0]  sel3;

   wb_sram_slave #(.data_width_p(64), .els_p(512), .wait_cycles_p(0)) dut0 (
      .clk_i(clk), .reset_i(rst0), .adr_i(adr0), .dat_i(dati0), .cyc_i(cyc0),
      .stb_i(stb0), .sel_i(sel0), .we_i(we0), .dat_o(dato0), .ack_o(ack0), .err_o(err0)
   );

   wb_sram_slave #(.data_width_p(64), .els_p(512), .wait_cycles_p(3)) dut3 (
      .clk_i(clk), .reset_i(rst3), .adr_i(adr3), .dat_i(dati3), .cyc_i(cyc3),
      .stb_i(stb3), .sel_i(sel3), .we_i(we3), .dat_o(dato3), .ack_o(ack3), .err_o(err3)
   );

   typedef struct {
      logic        is_err;
      logic        chk_data;
      logic [63:0] data;
      int          due;
      string       name;
   } exp_t;

   exp_t q0[$];
   exp_t q3[$];
   int   total   = 0;
   int   bad     = 0;
   int   cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
      end
   endtask

   task automatic driveBus(input int idx, input logic c, input logic s, input logic w,
                           input logic [9:0] a, input logic [63:0] d, input logic [7:0] m);
      if (idx == 0) begin
         cyc0 = c; stb0 = s; we0 = w; adr0 = a; dati0 = d; sel0 = m;
      end else begin
         cyc3 = c; stb3 = s; we3 = w; adr3 = a; dati3 = d; sel3 = m;
      end
   endtask

   task automatic pushExp(input int idx, input logic is_err, input logic chk,
                          input logic [63:0] d, input int due, input string name);
      exp_t x;
      x.is_err = is_err; x.chk_data = chk; x.data = d; x.due = due; x.name = name;
      if (idx == 0) q0.push_back(x);
      else          q3.push_back(x);
   endtask

   function automatic logic respSeen(input int idx);
      return (idx == 0) ? (ack0 | err0) : (ack3 | err3);
   endfunction

   // Bounded wait for ack/err; returns at the negedge on which it is visible.
   task automatic waitResp(input int idx, input string name, output logic got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (respSeen(idx)) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout: got no response, wanted ack or err", name);
         if (idx == 0 && q0.size() > 0) void'(q0.pop_back());
         if (idx != 0 && q3.size() > 0) void'(q3.pop_back());
      end
   endtask

   // Called at a negedge; returns at the negedge after the response.
   task automatic applyStimulus(input int idx, input logic w, input logic [9:0] a,
                                input logic [63:0] d, input logic [7:0] m,
                                input logic exp_err, input logic chk, input logic [63:0] exp_d,
                                input logic hold, input string name);
      logic got;
      int   lat;
      lat = (idx == 0) ? 2 : 5;
      driveBus(idx, 1'b1, 1'b1, w, a, d, m);
      pushExp(idx, exp_err, chk, exp_d, cyc_cnt + lat, name);
      waitResp(idx, name, got);
      if (!hold) driveBus(idx, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
   endtask

   task automatic monitorPort(input int idx, input logic a, input logic e, input logic [63:0] d);
      exp_t x;
      logic empty;
      if (a === 1'b1 || e === 1'b1) begin
         empty = (idx == 0) ? (q0.size() == 0) : (q3.size() == 0);
         if (empty) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected response dut%0d: got ack=%b err=%b, wanted none", idx, a, e);
         end else begin
            if (idx == 0) x = q0.pop_front();
            else          x = q3.pop_front();
            checkOutput({x.name, " ack"}, 64'(a), 64'(!x.is_err));
            checkOutput({x.name, " err"}, 64'(e), 64'(x.is_err));
            checkOutput({x.name, " cycle"}, 64'(cyc_cnt), 64'(x.due));
            if (x.chk_data) checkOutput({x.name, " dat_o"}, d, x.data);
         end
      end else begin
         checkOutput((idx == 0) ? "idle dat_o dut0" : "idle dat_o dut3", d, 64'h0);
      end
   endtask

   always @(negedge clk) begin
      monitorPort(0, ack0, err0, dato0);
      monitorPort(1, ack3, err3, dato3);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, wanted finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic got;
      rst0 = 1'b1;
      rst3 = 1'b1;
      driveBus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      driveBus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk);
      checkOutput("reset ack0", 64'(ack0), 64'h0);
      checkOutput("reset err0", 64'(err0), 64'h0);
      checkOutput("reset ack3", 64'(ack3), 64'h0);
      checkOutput("reset err3", 64'(err3), 64'h0);
      rst0 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);

      // No wait states: full write, partial writes, empty mask.
      applyStimulus(0, 1, 10'd3, 64'h1122334455667788, 8'hFF, 0, 0, 64'h0, 0, "w0 full");
      applyStimulus(0, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'h1122334455667788, 0, "r0 full");
      applyStimulus(0, 1, 10'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 64'h0, 0, "w0 low half");
      applyStimulus(0, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'h11223344AAAAAAAA, 0, "r0 low half");
      applyStimulus(0, 1, 10'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0, 64'h0, 0, "w0 sel zero");
      applyStimulus(0, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'h11223344AAAAAAAA, 0, "r0 sel zero");

      // Back-to-back requests with stb held high through each ack.
      applyStimulus(0, 1, 10'd511, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 0, 64'h0, 1, "b2b w511");
      applyStimulus(0, 1, 10'd511, 64'h5555555555555555, 8'h81, 0, 0, 64'h0, 1, "b2b w511 ends");
      applyStimulus(0, 1, 10'd5, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 64'h0, 1, "b2b w5");
      applyStimulus(0, 0, 10'd511, 64'h0, 8'hFF, 0, 1, 64'h55ADBEEFCAFEF055, 1, "b2b r511");
      applyStimulus(0, 0, 10'd5, 64'h0, 8'hFF, 0, 1, 64'h0123456789ABCDEF, 0, "b2b r5");

      // Out of range: error, zero data, and no aliasing into the low half.
      applyStimulus(0, 1, 10'd88, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 0, 0, 64'h0, 0, "w0 88");
      applyStimulus(0, 0, 10'd512, 64'h0, 8'hFF, 1, 1, 64'h0, 0, "r0 512 oob");
      applyStimulus(0, 1, 10'd600, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 1, 64'h0, 0, "w0 600 oob");
      applyStimulus(0, 0, 10'd1023, 64'h0, 8'hFF, 1, 1, 64'h0, 0, "r0 1023 oob");
      applyStimulus(0, 0, 10'd88, 64'h0, 8'hFF, 0, 1, 64'h0F0F0F0F0F0F0F0F, 0, "r0 88 intact");

      // Three wait states: latency t+5.
      applyStimulus(1, 1, 10'd3, 64'hCAFEBABE12345678, 8'hFF, 0, 0, 64'h0, 0, "w3 full");
      applyStimulus(1, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'hCAFEBABE12345678, 0, "r3 full");
      applyStimulus(1, 0, 10'd600, 64'h0, 8'hFF, 1, 1, 64'h0, 0, "r3 oob");

      // Abort by dropping cyc two cycles into the wait.
      driveBus(1, 1'b1, 1'b1, 1'b1, 10'd3, 64'h0, 8'hFF);
      repeat (2) @(negedge clk);
      driveBus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (10) @(negedge clk);
      applyStimulus(1, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'hCAFEBABE12345678, 0, "r3 after abort");

      // Asynchronous reset in the middle of the wait.
      driveBus(1, 1'b1, 1'b1, 1'b0, 10'd3, 64'h0, 8'hFF);
      repeat (2) @(negedge clk);
      #2 rst3 = 1'b1;
      #1;
      checkOutput("rst wait ack3", 64'(ack3), 64'h0);
      checkOutput("rst wait err3", 64'(err3), 64'h0);
      checkOutput("rst wait dat3", dato3, 64'h0);
      driveBus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk);
      rst3 = 1'b0;
      repeat (8) @(negedge clk);

      // Asynchronous reset while ack is high clears it without a clock edge.
      driveBus(1, 1'b1, 1'b1, 1'b0, 10'd3, 64'h0, 8'hFF);
      pushExp(1, 1'b0, 1'b1, 64'hCAFEBABE12345678, cyc_cnt + 5, "r3 before rst");
      waitResp(1, "r3 before rst", got);
      #2 rst3 = 1'b1;
      #1;
      checkOutput("rst resp ack3", 64'(ack3), 64'h0);
      checkOutput("rst resp dat3", dato3, 64'h0);
      driveBus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk);
      rst3 = 1'b0;
      @(negedge clk);

      applyStimulus(1, 0, 10'd3, 64'h0, 8'hFF, 0, 1, 64'hCAFEBABE12345678, 0, "r3 after rst");

      repeat (6) @(negedge clk);
      checkOutput("q0 drained", 64'(q0.size()), 64'h0);
      checkOutput("q3 drained", 64'(q3.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
